// File: rtl/ysyx_23060332_regfile_mp_if.sv
// Register-file access bundle: read ports, write port, busy-set port.
// master drives addresses/write/set; slave returns data, busy, ready.
interface ysyx_23060332_regfile_mp_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5,
  parameter int NRD  = 2
);
  logic                ready;
  logic [NRD*AW-1:0]   raddr;
  logic [NRD*XLEN-1:0] rdata;
  logic [NRD-1:0]      rbusy;
  logic                wen;
  logic [AW-1:0]       waddr;
  logic [XLEN-1:0]     wdata;
  logic                set_en;
  logic [AW-1:0]       set_addr;

  modport master (
    output raddr, wen, waddr, wdata,
    output set_en, set_addr,
    input  ready, rdata, rbusy
  );

  modport slave (
    input  raddr, wen, waddr, wdata,
    input  set_en, set_addr,
    output ready, rdata, rbusy
  );
endinterface

// File: rtl/ysyx_23060332_regfile_mp.sv
// Multi-read-port register file with busy scoreboard and clear sequencer.
// Ports: clk, rst (async high), bus (slave: NRD reads, 1 write, busy set).
module ysyx_23060332_regfile_mp #(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 32,
  parameter int NRD      = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input logic clk,
  input logic rst,
  ysyx_23060332_regfile_mp_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {CLEAR, READY} state_t;

  state_t          state_q;
  logic [AW-1:0]   clr_cnt_q;
  logic            ready_q;
  logic [DEPTH-1:0] busy_q, busy_d;
  logic [XLEN-1:0] mem [DEPTH];
  logic            wr_ok;
  logic [NRD*XLEN-1:0] rdata_c;
  logic [NRD-1:0]  rbusy_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      unique case (state_q)
        CLEAR: begin
          clr_cnt_q <= clr_cnt_q + 1'b1;
          if (clr_cnt_q == AW'(DEPTH-1)) begin
            state_q <= READY;
            ready_q <= 1'b1;
          end
        end
        READY: ready_q <= 1'b1;
        default: state_q <= CLEAR;
      endcase
    end
  end

  // Write to x0 is dropped when x0 is hardwired.
  assign wr_ok = ready_q && bus.wen &&
                 !((ZERO_REG != 0) && (bus.waddr == '0));

  // Storage has no reset; the sequencer zeroes it after rst.
  always_ff @(posedge clk) begin
    if (!ready_q)
      mem[clr_cnt_q] <= '0;
    else if (wr_ok)
      mem[bus.waddr] <= bus.wdata;
  end

  // Set is applied after clear so a newer producer wins.
  always_comb begin
    busy_d = busy_q;
    if (ready_q) begin
      if (bus.wen)    busy_d[bus.waddr]    = 1'b0;
      if (bus.set_en) busy_d[bus.set_addr] = 1'b1;
    end
    if (ZERO_REG != 0) busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  always_comb begin
    logic [AW-1:0] ra;
    rdata_c = '0;
    rbusy_c = '0;
    for (int k = 0; k < NRD; k++) begin
      ra = bus.raddr[k*AW +: AW];
      if (!ready_q || ((ZERO_REG != 0) && (ra == '0)))
        rdata_c[k*XLEN +: XLEN] = '0;
      else if ((BYPASS != 0) && wr_ok && (bus.waddr == ra))
        rdata_c[k*XLEN +: XLEN] = bus.wdata;
      else
        rdata_c[k*XLEN +: XLEN] = mem[ra];
      // Busy is pre-edge state only; bypass covers the data.
      rbusy_c[k] = ready_q & busy_q[ra];
    end
  end

  assign bus.rdata = rdata_c;
  assign bus.rbusy = rbusy_c;
  assign bus.ready = ready_q;
endmodule

// File: tb/tb_ysyx_23060332_regfile_mp.sv
// Bench for ysyx_23060332_regfile_mp: vector table + scoreboard queue.
// Runs a BYPASS=1 and a BYPASS=0 instance on the same stimulus.
module tb_ysyx_23060332_regfile_mp;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ysyx_23060332_regfile_mp_if #(.XLEN(32), .AW(5), .NRD(2)) b0 ();
  ysyx_23060332_regfile_mp_if #(.XLEN(32), .AW(5), .NRD(2)) b1 ();

  assign b1.raddr    = b0.raddr;
  assign b1.wen      = b0.wen;
  assign b1.waddr    = b0.waddr;
  assign b1.wdata    = b0.wdata;
  assign b1.set_en   = b0.set_en;
  assign b1.set_addr = b0.set_addr;

  ysyx_23060332_regfile_mp #(.BYPASS(1)) u0 (
    .clk(clk), .rst(rst), .bus(b0)
  );
  ysyx_23060332_regfile_mp #(.BYPASS(0)) u1 (
    .clk(clk), .rst(rst), .bus(b1)
  );

  typedef struct {
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        set_en;
    logic [4:0]  set_addr;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [31:0] enb0;
    logic [1:0]  eb;
  } vec_t;

  typedef struct {
    logic [31:0] e0;
    logic [31:0] e1;
    logic [31:0] enb0;
    logic [1:0]  eb;
  } exp_t;

  exp_t sbq[$];
  vec_t vecs[13];
  int n_cmp = 0;
  int n_err = 0;

  function automatic vec_t mk(
    logic w, logic [4:0] wa, logic [31:0] wd,
    logic s, logic [4:0] sa,
    logic [4:0] r0, logic [4:0] r1,
    logic [31:0] e0, logic [31:0] e1,
    logic [31:0] en, logic [1:0] eb
  );
    vec_t v;
    v.wen = w; v.waddr = wa; v.wdata = wd;
    v.set_en = s; v.set_addr = sa;
    v.ra0 = r0; v.ra1 = r1;
    v.e0 = e0; v.e1 = e1; v.enb0 = en; v.eb = eb;
    return v;
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic idle();
    b0.wen = 1'b0;
    b0.set_en = 1'b0;
  endtask

  task automatic drive(vec_t v);
    exp_t e;
    b0.wen = v.wen; b0.waddr = v.waddr; b0.wdata = v.wdata;
    b0.set_en = v.set_en; b0.set_addr = v.set_addr;
    b0.raddr = {v.ra1, v.ra0};
    e.e0 = v.e0; e.e1 = v.e1; e.enb0 = v.enb0; e.eb = v.eb;
    sbq.push_back(e);
  endtask

  task automatic compare(string tag);
    exp_t e;
    if (sbq.size() == 0) begin
      check({tag, ".sbq_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sbq.pop_front();
    check({tag, ".rd0"}, b0.rdata[31:0], e.e0);
    check({tag, ".rd1"}, b0.rdata[63:32], e.e1);
    check({tag, ".nb_rd0"}, b1.rdata[31:0], e.enb0);
    check({tag, ".busy"}, {30'd0, b0.rbusy}, {30'd0, e.eb});
  endtask

  task automatic wait_ready(string tag);
    int cnt = 0;
    while (cnt < 100) begin
      @(posedge clk);
      #1;
      cnt++;
      if (b0.ready) break;
    end
    idle();
    check(tag, cnt, 32);
  endtask

  task automatic read_zero(string tag, logic [4:0] a0, logic [4:0] a1);
    @(negedge clk);
    drive(mk(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, a0, a1,
             32'd0, 32'd0, 32'd0, 2'b00));
    #2;
    compare(tag);
  endtask

  initial begin
    vecs[0]  = mk(0, 0, 0, 0, 0, 0, 1,
                  0, 0, 0, 2'b00);
    vecs[1]  = mk(1, 3, 32'h12345678, 0, 0, 3, 3,
                  32'h12345678, 32'h12345678, 0, 2'b00);
    vecs[2]  = mk(0, 0, 0, 0, 0, 3, 5,
                  32'h12345678, 0, 32'h12345678, 2'b00);
    vecs[3]  = mk(1, 0, 32'hFFFFFFFF, 1, 0, 0, 3,
                  0, 32'h12345678, 0, 2'b00);
    vecs[4]  = mk(0, 0, 0, 0, 0, 0, 0,
                  0, 0, 0, 2'b00);
    vecs[5]  = mk(0, 0, 0, 1, 7, 7, 3,
                  0, 32'h12345678, 0, 2'b00);
    vecs[6]  = mk(1, 7, 32'hAAAA5555, 1, 7, 7, 7,
                  32'hAAAA5555, 32'hAAAA5555, 0, 2'b11);
    vecs[7]  = mk(1, 7, 32'h11112222, 0, 0, 7, 2,
                  32'h11112222, 0, 32'hAAAA5555, 2'b01);
    vecs[8]  = mk(0, 0, 0, 0, 0, 7, 3,
                  32'h11112222, 32'h12345678, 32'h11112222, 2'b00);
    vecs[9]  = mk(1, 10, 32'hCAFEF00D, 1, 9, 9, 10,
                  0, 32'hCAFEF00D, 0, 2'b00);
    vecs[10] = mk(0, 0, 0, 0, 0, 9, 10,
                  0, 32'hCAFEF00D, 0, 2'b01);
    vecs[11] = mk(1, 31, 32'h80000001, 0, 0, 31, 30,
                  32'h80000001, 0, 0, 2'b00);
    vecs[12] = mk(0, 0, 0, 0, 0, 31, 31,
                  32'h80000001, 32'h80000001, 32'h80000001, 2'b00);

    rst = 1'b1;
    idle();
    b0.waddr = '0; b0.wdata = '0; b0.set_addr = '0; b0.raddr = '0;
    #12;
    @(negedge clk);
    rst = 1'b0;
    wait_ready("ready_first");

    // Fill the array with garbage so the clear sequence is observable.
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      b0.wen = 1'b1;
      b0.waddr = 5'(i);
      b0.wdata = $urandom | 32'h1;
    end
    @(negedge clk);
    idle();

    rst = 1'b1;
    #1;
    check("rst_ready", {31'd0, b0.ready}, 32'd0);
    b0.wen = 1'b1; b0.waddr = 5'd5; b0.wdata = 32'hDEADBEEF;
    b0.set_en = 1'b1; b0.set_addr = 5'd6;
    b0.raddr = {5'd6, 5'd5};
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("clr_rd0", b0.rdata[31:0], 32'd0);
    check("clr_busy", {30'd0, b0.rbusy}, 32'd0);
    wait_ready("ready_after_clear");

    for (int i = 0; i < 32; i++)
      read_zero($sformatf("zero%0d", i), 5'(i), 5'(31 - i));

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #2;
      compare($sformatf("v%0d", i));
    end

    @(negedge clk);
    idle();
    b0.wen = 1'b1; b0.waddr = 5'd4; b0.wdata = 32'h00000055;
    b0.raddr = {5'd9, 5'd4};
    #2;
    check("pre_rst_busy", {30'd0, b0.rbusy}, 32'd2);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("mid_rst_ready", {31'd0, b0.ready}, 32'd0);
    check("mid_rst_busy", {30'd0, b0.rbusy}, 32'd0);
    check("mid_rst_rd0", b0.rdata[31:0], 32'd0);
    @(negedge clk);
    rst = 1'b0;
    wait_ready("ready_after_mid_rst");
    read_zero("post3_7", 5'd3, 5'd7);
    read_zero("post10_31", 5'd10, 5'd31);
    read_zero("post4_9", 5'd4, 5'd9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ysyx_23060332_regfile_mp.md
Name: ysyx_23060332_regfile_mp

Overview:
- Parametrised general-purpose register file for the NPC core; successor to the single-read-port register block.
- Provides NRD combinational read ports, one synchronous write port and optional write-to-read bypass.
- Includes a per-register busy scoreboard for issue-stage hazard detection.
- Replaces the flop-reset array with a post-reset clear sequencer, so array storage needs no reset.

Parameters:
- XLEN, 32, data width in bits.
- DEPTH, 32, number of architectural registers (16 for RV32E); power of two, at least 2.
- NRD, 2, number of read ports; at least 1.
- BYPASS, 1, when 1 a same-cycle write is forwarded to matching read ports.
- ZERO_REG, 1, when 1 register 0 reads as zero, ignores writes and is never busy.
- AW (localparam), $clog2(DEPTH), address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- ready  out  1  high once the clear sequence is complete.
- raddr  in  NRD*AW  read addresses; port k uses bits [k*AW +: AW].
- rdata  out  NRD*XLEN  read data; port k uses bits [k*XLEN +: XLEN].
- rbusy  out  NRD  port k is high when register raddr[k] is busy.
- wen  in  1  write enable.
- waddr  in  AW  write address.
- wdata  in  XLEN  write data.
- set_en  in  1  mark register set_addr busy (instruction issued).
- set_addr  in  AW  register to mark busy.

Behaviour:
- Reset (async assert): ready=0, state=CLEAR, clr_cnt=0, all busy bits=0. Array contents are unaffected until the clear sequence rewrites them.
- CLEAR state:
  - Each cycle writes 0 to entry clr_cnt, then clr_cnt increments.
  - When clr_cnt==DEPTH-1 is written, the next state is READY; clr_cnt wraps, no overflow.
  - ready rises exactly DEPTH rising edges after rst deasserts.
- During CLEAR:
  - wen and set_en are ignored.
  - All rdata read 0 and all rbusy read 0.
- READY state:
  - Stays in READY until rst asserts.
  - rst asserted mid-operation returns to CLEAR immediately (async) and restarts from clr_cnt=0.
- Write:
  - On the rising edge with wen=1 and ready=1, mem[waddr] <= wdata.
  - With ZERO_REG=1 and waddr=0, the write is dropped.
- Read, combinational, per port k:
  - ZERO_REG=1 and raddr[k]=0: output 0.
  - Else BYPASS=1, wen=1, ready=1, waddr==raddr[k] and waddr nonzero (or ZERO_REG=0): output wdata.
  - Else: output mem[raddr[k]].
  - All ports are independent; the same address on several ports is legal.
- Scoreboard, busy[DEPTH]:
  - set_en=1 sets busy[set_addr].
  - wen=1 clears busy[waddr]; the write-back retires the producer.
  - Same address, same cycle: set wins (the newer producer stays outstanding), and busy stays 1.
  - Different addresses, same cycle: both take effect.
  - ZERO_REG=1: busy[0] is always 0.
- rbusy[k] = busy[raddr[k]], registered state only. It does not account for a same-cycle wen, so bypass covers data and busy reflects the pre-edge state.
- rbusy is forced 0 when ready=0.
- Widths: addresses are unsigned AW bits; no out-of-range addresses exist since DEPTH=2^AW.
- Latency:
  - Read: 0 cycles.
  - Write visible via array: 1 cycle.
  - Via bypass: 0 cycles.

Test Plan:
- Pulse rst high, with array preloaded with garbage by a prior run -> ready=0 for 32 cycles and rises on the 32nd edge; all regs then read 0 on both ports.
- Assert wen with waddr=5, wdata=0xDEADBEEF during CLEAR -> ignored; reg 5 reads 0 after ready.
- In READY, write reg 3 = 0x12345678 with raddr0=3, raddr1=3 the same cycle -> both rdata=0x12345678 via bypass (BYPASS=1). With BYPASS=0 -> old value 0 that cycle and 0x12345678 next cycle.
- Write reg 0 = 0xFFFFFFFF with set_en on addr 0 -> rdata for raddr=0 is 0 and rbusy=0.
- set_en on addr 7, then raddr0=7 -> rbusy0=1. Next cycle set_en=1 and wen=1 both on addr 7 -> rbusy0 stays 1. Following cycle wen only on addr 7 -> rbusy0=0 after the edge.
- Assert rst asynchronously mid-write-stream (between edges) -> ready drops immediately and all rbusy=0; sequence restarts and ready returns after DEPTH edges; previously written regs read 0.
